// File: rtl/line_burst_adapter.sv
// Line-to-burst adapter: serves one 256-bit cache line request at a time as a
// fixed 4-beat burst on the 64-bit physical memory bus.
module line_burst_adapter #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [ADDR_W-1:0]  burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int unsigned BEATS    = LINE_W / BURST_W;
    localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               last_beat;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wline_q;
    logic [LINE_W-1:0]  rdata_q;
    logic               resp_q;
    logic               bread_q;
    logic               bwrite_q;
    logic [BURST_W-1:0] bwdata_q;

    // Byte offset within the line is irrelevant: bursts are always line aligned.
    logic addr_offset_unused;
    assign addr_offset_unused = ^pmem_address[OFFSET_W-1:0];

    // Beat counter increment and final-beat detect.
    always_comb begin
        count_d   = count_q + CNT_W'(1);
        last_beat = (count_q == CNT_W'(BEATS - 1));
    end

    // Request acceptance, beat sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            wline_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
            bread_q  <= 1'b0;
            bwrite_q <= 1'b0;
            bwdata_q <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Read wins when both are raised; the write is dropped.
                    if (pmem_read) begin
                        state_q <= RD_BURST;
                        addr_q  <= {pmem_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                        count_q <= '0;
                    end else if (pmem_write) begin
                        state_q <= WR_BURST;
                        addr_q  <= {pmem_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                        wline_q <= pmem_wdata;
                        count_q <= '0;
                    end
                end
                RD_BURST: begin
                    if (!bread_q) begin
                        bread_q <= 1'b1;
                    end else if (burst_resp) begin
                        for (int k = 0; k < int'(BEATS); k++) begin
                            if (count_q == CNT_W'(k)) begin
                                rdata_q[k*BURST_W +: BURST_W] <= burst_rdata;
                            end
                        end
                        count_q <= count_d;
                        if (last_beat) begin
                            bread_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (!bwrite_q) begin
                        bwrite_q <= 1'b1;
                        bwdata_q <= wline_q[BURST_W-1:0];
                    end else if (burst_resp) begin
                        for (int k = 0; k < int'(BEATS) - 1; k++) begin
                            if (count_q == CNT_W'(k)) begin
                                bwdata_q <= wline_q[(k+1)*BURST_W +: BURST_W];
                            end
                        end
                        count_q <= count_d;
                        if (last_beat) begin
                            bwrite_q <= 1'b0;
                            bwdata_q <= '0;
                            resp_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = bread_q;
    assign burst_write   = bwrite_q;
    assign burst_wdata   = bwdata_q;

endmodule
